// File: rtl/vga_timing_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_timing_pkg                                                       |
// | Shared coordinate type, 640x480@60 timing defaults, sync decode.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int c_h_active = 640;
  localparam int c_h_fp     = 16;
  localparam int c_h_sync   = 96;
  localparam int c_h_bp     = 48;
  localparam int c_v_active = 480;
  localparam int c_v_fp     = 10;
  localparam int c_v_sync   = 2;
  localparam int c_v_bp     = 33;

  // One extra bit so start+width cannot wrap at the top of the coordinate range.
  function automatic logic sync_active(input coord_t pos, input coord_t start, input coord_t width);
    logic [10:0] stop;
    stop = {1'b0, start} + {1'b0, width};
    return ({1'b0, pos} >= {1'b0, start}) && ({1'b0, pos} < stop);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_axis_counter                                                     |
// | Wrapping 0..TOTAL-1 counter for one raster axis; resets to TOTAL-1.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL = c_h_active + c_h_fp + c_h_sync + c_h_bp
) (
  input  logic       vga_clk,
  input  logic       rst_n,
  input  logic       enable,
  output logic [9:0] count,
  output logic       terminal
);

  localparam coord_t c_last = coord_t'(TOTAL - 1);

  assign terminal = (count == c_last);

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= c_last;
    end else if (enable) begin
      count <= terminal ? '0 : count + 10'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_timing_gen                                                       |
// | Raster timing: DrawX/DrawY, blank, active-low hs/vs, line/frame      |
// | strobes. Optional frame_cnt port under VGA_FRAME_CNT_EN.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = c_h_active,
  parameter int H_FP     = c_h_fp,
  parameter int H_SYNC   = c_h_sync,
  parameter int H_BP     = c_h_bp,
  parameter int V_ACTIVE = c_v_active,
  parameter int V_FP     = c_v_fp,
  parameter int V_SYNC   = c_v_sync,
  parameter int V_BP     = c_v_bp
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        line_start,
  output logic        frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int     c_h_tot      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int     c_v_tot      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam coord_t c_h_act      = coord_t'(H_ACTIVE);
  localparam coord_t c_v_act      = coord_t'(V_ACTIVE);
  localparam coord_t c_hs_start   = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t c_hs_width   = coord_t'(H_SYNC);
  localparam coord_t c_vs_start   = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t c_vs_width   = coord_t'(V_SYNC);

  if (c_h_tot > 1024) begin : g_h_tot_check
    $error("vga_timing_gen: horizontal total exceeds 1024");
  end
  if (c_v_tot > 1024) begin : g_v_tot_check
    $error("vga_timing_gen: vertical total exceeds 1024");
  end

  // Reset asserts asynchronously, releases two clocks later on a clean edge.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  logic [9:0] w_h_count;
  logic [9:0] w_v_count;
  logic       w_h_term;
  logic       w_v_term;

  vga_axis_counter #(.TOTAL(c_h_tot)) u_h_counter (
    .vga_clk  (vga_clk),
    .rst_n    (w_rst_n),
    .enable   (1'b1),
    .count    (w_h_count),
    .terminal (w_h_term)
  );

  vga_axis_counter #(.TOTAL(c_v_tot)) u_v_counter (
    .vga_clk  (vga_clk),
    .rst_n    (w_rst_n),
    .enable   (w_h_term),
    .count    (w_v_count),
    .terminal (w_v_term)
  );

  assign DrawX = w_h_count;
  assign DrawY = w_v_count;

  // Decoding the upcoming position keeps the registered flags aligned with DrawX/DrawY.
  coord_t w_h_next;
  coord_t w_v_next;

  always_comb begin
    w_h_next = w_h_term ? '0 : w_h_count + 10'd1;
    w_v_next = w_v_count;
    if (w_h_term) begin
      w_v_next = w_v_term ? '0 : w_v_count + 10'd1;
    end
  end

  logic r_blank;
  logic r_hs;
  logic r_vs;
  logic r_line_start;
  logic r_frame_start;

  always_ff @(posedge vga_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_blank       <= 1'b0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_blank       <= (w_h_next < c_h_act) && (w_v_next < c_v_act);
      r_hs          <= ~sync_active(w_h_next, c_hs_start, c_hs_width);
      r_vs          <= ~sync_active(w_v_next, c_vs_start, c_vs_width);
      r_line_start  <= (w_h_next == '0);
      r_frame_start <= (w_h_next == '0) && (w_v_next == '0);
    end
  end

  assign blank       = r_blank;
  assign hs          = r_hs;
  assign vs          = r_vs;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge vga_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_frame_cnt <= '0;
    end else if ((w_h_next == '0) && (w_v_next == '0)) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vga_timing_gen                                                    |
// | Bench: scaled-timing instance against a position model, plus a       |
// | default-timing instance for line-level checks.                       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_vga_timing_gen;

  localparam int H_ACTIVE = 40, H_FP = 4, H_SYNC = 8, H_BP = 6;
  localparam int V_ACTIVE = 30, V_FP = 3, V_SYNC = 2, V_BP = 5;
  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME = H_TOT * V_TOT;

  logic        vga_clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [9:0]  DrawX, DrawY, d_DrawX, d_DrawY;
  logic        blank, hs, vs, line_start, frame_start;
  logic        d_blank, d_hs, d_vs, d_line_start, d_frame_start;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt, d_frame_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int n = 0;

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .hs(hs), .vs(vs), .line_start(line_start), .frame_start(frame_start)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  vga_timing_gen dut_def (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(d_DrawX), .DrawY(d_DrawY),
    .blank(d_blank), .hs(d_hs), .vs(d_vs), .line_start(d_line_start), .frame_start(d_frame_start)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(d_frame_cnt)
`endif
  );

  // Reference rules, written directly from the timing definitions.
  function automatic logic m_hs(int x);
    return !(x >= H_ACTIVE + H_FP && x < H_ACTIVE + H_FP + H_SYNC);
  endfunction
  function automatic logic m_vs(int y);
    return !(y >= V_ACTIVE + V_FP && y < V_ACTIVE + V_FP + V_SYNC);
  endfunction
  function automatic logic m_blank(int x, int y);
    return (x < H_ACTIVE) && (y < V_ACTIVE);
  endfunction

  task automatic tick();
    @(negedge vga_clk);
    n++;
  endtask

  function automatic logic in_reset_state();
    return DrawX === 10'(H_TOT - 1) && DrawY === 10'(V_TOT - 1) && blank === 1'b0 &&
           hs === 1'b1 && vs === 1'b1 && line_start === 1'b0 && frame_start === 1'b0;
  endfunction

  task automatic wait_pos(input int x, input int y, input string tag);
    int i;
    for (i = 0; i < FRAME + H_TOT && !(DrawX == 10'(x) && DrawY == 10'(y)); i++) tick();
    checks++;
    if (!(DrawX == 10'(x) && DrawY == 10'(y))) begin
      errors++;
      $display("FAIL %s_wait: position (%0d,%0d) not reached, required (%0d,%0d)", tag, DrawX, DrawY, x, y);
    end
  endtask

  // Release reset at a negedge; expect reset values held until the first (0,0).
  task automatic release_reset(input string tag);
    int found = 0, held_bad = 0;
    reset_n = 1'b1;
    for (int i = 0; i < 6 && found == 0; i++) begin
      @(negedge vga_clk);
      if (frame_start === 1'b1) found = 1;
      else if (!in_reset_state()) held_bad++;
    end
    n = 0;
    checks++;
    if (found != 1 || held_bad != 0) begin
      errors++;
      $display("FAIL %s_release: found=%0d held_bad=%0d, required found=1 held_bad=0", tag, found, held_bad);
    end
    checks++;
    if (DrawX !== 10'd0 || DrawY !== 10'd0 || blank !== 1'b1 || hs !== 1'b1 || vs !== 1'b1 ||
        line_start !== 1'b1 || frame_start !== 1'b1) begin
      errors++;
      $display("FAIL %s_first_pixel: (%0d,%0d) blank=%b hs=%b vs=%b ls=%b fs=%b, required (0,0) 1 1 1 1 1",
               tag, DrawX, DrawY, blank, hs, vs, line_start, frame_start);
    end
`ifdef VGA_FRAME_CNT_EN
    checks++;
    if (frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL %s_frame_cnt_first: got %0d, required 1", tag, frame_cnt);
    end
`endif
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    repeat (3) @(negedge vga_clk);
    checks++;
    if (!in_reset_state()) begin
      errors++;
      $display("FAIL reset_state: (%0d,%0d) blank=%b hs=%b vs=%b ls=%b fs=%b, required (%0d,%0d) 0 1 1 0 0",
               DrawX, DrawY, blank, hs, vs, line_start, frame_start, H_TOT - 1, V_TOT - 1);
    end
    checks++;
    if (d_DrawX !== 10'd799 || d_DrawY !== 10'd524 || d_blank !== 1'b0 || d_hs !== 1'b1 || d_vs !== 1'b1) begin
      errors++;
      $display("FAIL reset_state_default: (%0d,%0d) blank=%b hs=%b vs=%b, required (799,524) 0 1 1",
               d_DrawX, d_DrawY, d_blank, d_hs, d_vs);
    end
`ifdef VGA_FRAME_CNT_EN
    checks++;
    if (frame_cnt !== 16'd0 || d_frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_frame_cnt: got %0d/%0d, required 0", frame_cnt, d_frame_cnt);
    end
`endif
    release_reset("reset");
    checks++;
    if (d_DrawX !== 10'd0 || d_DrawY !== 10'd0 || d_frame_start !== 1'b1 || d_blank !== 1'b1) begin
      errors++;
      $display("FAIL default_first_pixel: (%0d,%0d) fs=%b blank=%b, required (0,0) 1 1",
               d_DrawX, d_DrawY, d_frame_start, d_blank);
    end
  endtask

  // 640x480 instance: line 0 and line 1 just after release.
  task automatic test_defaults();
    int low_cnt = 0, first_low = -1, last_low = -1, blank_fall = -1, ls_cnt = 0, ls_bad = 0, other_bad = 0;
    int last_ls = -1;
    for (int i = 0; i <= 1600; i++) begin
      if (i < 800) begin
        if (d_hs === 1'b0) begin
          low_cnt++;
          if (first_low < 0) first_low = int'(d_DrawX);
          last_low = int'(d_DrawX);
        end
        if (d_blank === 1'b0 && blank_fall < 0) blank_fall = int'(d_DrawX);
        if (d_DrawY !== 10'd0 || d_vs !== 1'b1) other_bad++;
      end
      if (d_line_start === 1'b1) begin
        if (last_ls >= 0 && i - last_ls != 800) ls_bad++;
        last_ls = i;
        ls_cnt++;
      end
      if (d_frame_start === 1'b1 && i != 0) other_bad++;
      tick();
    end
    checks++;
    if (low_cnt != 96 || first_low != 656 || last_low != 751) begin
      errors++;
      $display("FAIL default_hsync: low=%0d from %0d to %0d, required 96 from 656 to 751", low_cnt, first_low, last_low);
    end
    checks++;
    if (blank_fall != 640) begin
      errors++;
      $display("FAIL default_blank_fall: DrawX=%0d, required 640", blank_fall);
    end
    checks++;
    if (ls_cnt != 3 || ls_bad != 0 || other_bad != 0) begin
      errors++;
      $display("FAIL default_line_start: pulses=%0d bad_period=%0d other=%0d, required 3 0 0", ls_cnt, ls_bad, other_bad);
    end
  endtask

  task automatic test_frame_timing();
    int bad = 0, first_bad = -1, fs_cnt = 0, fs_bad = 0, ls_bad = 0, max_x = 0;
    int last_fs = -1, last_ls = -1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      int x = n % H_TOT;
      int y = (n / H_TOT) % V_TOT;
      if (DrawX !== 10'(x) || DrawY !== 10'(y) || blank !== m_blank(x, y) || hs !== m_hs(x) ||
          vs !== m_vs(y) || line_start !== (x == 0) || frame_start !== (x == 0 && y == 0)) begin
        bad++;
        if (first_bad < 0) first_bad = n;
      end
`ifdef VGA_FRAME_CNT_EN
      if (frame_cnt !== 16'(n / FRAME + 1)) begin
        bad++;
        if (first_bad < 0) first_bad = n;
      end
`endif
      if (int'(DrawX) > max_x) max_x = int'(DrawX);
      if (frame_start === 1'b1) begin
        if (last_fs >= 0 && i - last_fs != FRAME) fs_bad++;
        last_fs = i;
        fs_cnt++;
      end
      if (line_start === 1'b1) begin
        if (last_ls >= 0 && i - last_ls != H_TOT) ls_bad++;
        last_ls = i;
      end
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL model_compare: %0d bad cycles, first at cycle %0d, required 0", bad, first_bad);
    end
    checks++;
    if (fs_cnt != 3 || fs_bad != 0) begin
      errors++;
      $display("FAIL frame_start_period: pulses=%0d bad=%0d, required 3 0", fs_cnt, fs_bad);
    end
    checks++;
    if (ls_bad != 0 || max_x >= H_TOT) begin
      errors++;
      $display("FAIL line_period: bad=%0d max_x=%0d, required 0 and < %0d", ls_bad, max_x, H_TOT);
    end
  endtask

  task automatic test_hsync();
    int low_cnt = 0, first_low = -1, last_low = -1, blank_fall = -1;
    wait_pos(0, 0, "hsync");
    for (int i = 0; i < H_TOT; i++) begin
      if (hs === 1'b0) begin
        low_cnt++;
        if (first_low < 0) first_low = int'(DrawX);
        last_low = int'(DrawX);
      end
      if (blank === 1'b0 && blank_fall < 0) blank_fall = int'(DrawX);
      tick();
    end
    checks++;
    if (low_cnt != H_SYNC || first_low != H_ACTIVE + H_FP || last_low != H_ACTIVE + H_FP + H_SYNC - 1 ||
        blank_fall != H_ACTIVE) begin
      errors++;
      $display("FAIL hsync_line0: low=%0d %0d..%0d fall=%0d, required %0d %0d..%0d fall=%0d", low_cnt, first_low,
               last_low, blank_fall, H_SYNC, H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC - 1, H_ACTIVE);
    end
  endtask

  task automatic test_vsync();
    int low_cnt = 0, edges = 0, edge_bad = 0, blank_bad = 0, first_low_y = -1;
    logic prev;
    wait_pos(0, 0, "vsync");
    prev = vs;
    for (int i = 0; i < FRAME; i++) begin
      if (vs === 1'b0) begin
        low_cnt++;
        if (first_low_y < 0) first_low_y = int'(DrawY);
      end
      if (i > 0 && vs !== prev) begin
        edges++;
        if (DrawX !== 10'd0) edge_bad++;
      end
      if (int'(DrawY) >= V_ACTIVE && blank !== 1'b0) blank_bad++;
      prev = vs;
      tick();
    end
    checks++;
    if (low_cnt != V_SYNC * H_TOT || first_low_y != V_ACTIVE + V_FP) begin
      errors++;
      $display("FAIL vsync_width: low=%0d first_y=%0d, required %0d %0d", low_cnt, first_low_y, V_SYNC * H_TOT,
               V_ACTIVE + V_FP);
    end
    checks++;
    if (edges != 2 || edge_bad != 0) begin
      errors++;
      $display("FAIL vsync_edges: edges=%0d off_x0=%0d, required 2 0", edges, edge_bad);
    end
    checks++;
    if (blank_bad != 0) begin
      errors++;
      $display("FAIL vblank: %0d visible cycles below active, required 0", blank_bad);
    end
  endtask

  task automatic test_wrap();
    wait_pos(H_TOT - 1, V_TOT - 1, "wrap_frame");
    tick();
    checks++;
    if (DrawX !== 10'd0 || DrawY !== 10'd0) begin
      errors++;
      $display("FAIL wrap_frame: (%0d,%0d), required (0,0)", DrawX, DrawY);
    end
    wait_pos(H_TOT - 1, 10, "wrap_line");
    tick();
    checks++;
    if (DrawX !== 10'd0 || DrawY !== 10'd11) begin
      errors++;
      $display("FAIL wrap_line: (%0d,%0d), required (0,11)", DrawX, DrawY);
    end
  endtask

  task automatic test_mid_reset();
    int tx = int'($urandom_range(1, H_TOT - 2));
    int ty = int'($urandom_range(1, V_TOT - 2));
    int hold = int'($urandom_range(1, 4));
    int held_bad = 0;
    wait_pos(tx, ty, "mid_reset");
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (!in_reset_state()) begin
      errors++;
      $display("FAIL mid_reset_async at (%0d,%0d): (%0d,%0d) blank=%b hs=%b vs=%b, required (%0d,%0d) 0 1 1",
               tx, ty, DrawX, DrawY, blank, hs, vs, H_TOT - 1, V_TOT - 1);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge vga_clk);
      if (!in_reset_state()) held_bad++;
    end
    checks++;
    if (held_bad != 0) begin
      errors++;
      $display("FAIL mid_reset_hold: %0d cycles off reset state, required 0", held_bad);
    end
    release_reset("mid_reset");
  endtask

`ifdef VGA_FRAME_CNT_EN
  task automatic test_frame_cnt();
    @(negedge vga_clk);
    #2 reset_n = 1'b0;
    repeat (2) @(negedge vga_clk);
    checks++;
    if (frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL frame_cnt_reset: got %0d, required 0", frame_cnt);
    end
    release_reset("frame_cnt");
    for (int k = 2; k <= 3; k++) begin
      for (int i = 0; i < FRAME; i++) tick();
      checks++;
      if (frame_start !== 1'b1 || frame_cnt !== 16'(k)) begin
        errors++;
        $display("FAIL frame_cnt_step: fs=%b cnt=%0d, required fs=1 cnt=%0d", frame_start, frame_cnt, k);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_defaults();
    test_frame_timing();
    test_hsync();
    test_vsync();
    test_wrap();
    test_mid_reset();
    test_mid_reset();
    test_frame_timing();
`ifdef VGA_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
